id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the RV32IM pipeline. Captures a decoded instruction, resolves register-operand forwarding from the EX/MEM/WB stages, selects the ALU operands, and presents `EX_DATA1`/`EX_DATA2`/`EX_SELECT` straight to the ALU's `DATA1`/`DATA2`/`SELECT`. It also detects load-use hazards, inserts bubbles, honours stall/flush, and counts inserted bubbles.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32IM core: operand forwarding, ALU operand select,
// load-use bubble insertion, stall/flush handling and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ID_VALID,
  output logic            ID_READY,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_DATA1,
  input  logic [XLEN-1:0] ID_DATA2,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [4:0]      ID_RS1,
  input  logic [4:0]      ID_RS2,
  input  logic [4:0]      ID_RD,
  input  logic            ID_USES_RS1,
  input  logic            ID_USES_RS2,
  input  logic            ID_OP1_SEL,
  input  logic            ID_OP2_SEL,
  input  logic [4:0]      ID_SELECT,
  input  logic            ID_REG_WRITE,
  input  logic            ID_MEM_READ,
  input  logic            ID_MEM_WRITE,
  input  logic [XLEN-1:0] ALU_RESULT,
  input  logic [4:0]      MEM_RD,
  input  logic [4:0]      WB_RD,
  input  logic            MEM_REG_WRITE,
  input  logic            WB_REG_WRITE,
  input  logic [XLEN-1:0] MEM_RESULT,
  input  logic [XLEN-1:0] WB_RESULT,
  input  logic            STALL,
  input  logic            FLUSH,
  output logic            EX_VALID,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_DATA1,
  output logic [XLEN-1:0] EX_DATA2,
  output logic [XLEN-1:0] EX_STORE_DATA,
  output logic [4:0]      EX_SELECT,
  output logic [4:0]      EX_RD,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE,
  output logic            LOAD_USE_HAZARD,
  output logic [31:0]     BUBBLE_COUNT
);

  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_ex_fwd_ok;

  // A load in EX has no result yet; that case is covered by the hazard bubble instead.
  assign w_ex_fwd_ok = EX_VALID & EX_REG_WRITE & ~EX_MEM_READ;

  always_comb begin
    w_fwd1 = ID_DATA1;
    if (ID_RS1 != 5'd0) begin
      if (w_ex_fwd_ok && (EX_RD == ID_RS1))            w_fwd1 = ALU_RESULT;
      else if (MEM_REG_WRITE && (MEM_RD == ID_RS1))    w_fwd1 = MEM_RESULT;
      else if (WB_REG_WRITE && (WB_RD == ID_RS1))      w_fwd1 = WB_RESULT;
    end
  end

  always_comb begin
    w_fwd2 = ID_DATA2;
    if (ID_RS2 != 5'd0) begin
      if (w_ex_fwd_ok && (EX_RD == ID_RS2))            w_fwd2 = ALU_RESULT;
      else if (MEM_REG_WRITE && (MEM_RD == ID_RS2))    w_fwd2 = MEM_RESULT;
      else if (WB_REG_WRITE && (WB_RD == ID_RS2))      w_fwd2 = WB_RESULT;
    end
  end

  assign LOAD_USE_HAZARD = EX_VALID & EX_MEM_READ & (EX_RD != 5'd0) & ID_VALID &
                           ((ID_USES_RS1 & (ID_RS1 == EX_RD)) |
                            (ID_USES_RS2 & (ID_RS2 == EX_RD)));

  assign ID_READY = ~STALL & ~LOAD_USE_HAZARD;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      EX_VALID      <= 1'b0;
      EX_PC         <= '0;
      EX_DATA1      <= '0;
      EX_DATA2      <= '0;
      EX_STORE_DATA <= '0;
      EX_SELECT     <= 5'd0;
      EX_RD         <= 5'd0;
      EX_REG_WRITE  <= 1'b0;
      EX_MEM_READ   <= 1'b0;
      EX_MEM_WRITE  <= 1'b0;
      BUBBLE_COUNT  <= 32'd0;
    end else if (!FLUSH && STALL) begin
      // Frozen: every output keeps its value.
    end else if (FLUSH || LOAD_USE_HAZARD || !ID_VALID) begin
      EX_VALID      <= 1'b0;
      EX_PC         <= '0;
      EX_DATA1      <= '0;
      EX_DATA2      <= '0;
      EX_STORE_DATA <= '0;
      EX_SELECT     <= 5'd0;
      EX_RD         <= 5'd0;
      EX_REG_WRITE  <= 1'b0;
      EX_MEM_READ   <= 1'b0;
      EX_MEM_WRITE  <= 1'b0;
      if (!FLUSH && LOAD_USE_HAZARD && (BUBBLE_COUNT != 32'hFFFF_FFFF)) begin
        BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
      end
    end else begin
      EX_VALID      <= 1'b1;
      EX_PC         <= ID_PC;
      EX_DATA1      <= ID_OP1_SEL ? ID_PC : w_fwd1;
      EX_DATA2      <= ID_OP2_SEL ? ID_IMM : w_fwd2;
      EX_STORE_DATA <= w_fwd2;
      EX_SELECT     <= ID_SELECT;
      EX_RD         <= ID_RD;
      EX_REG_WRITE  <= ID_REG_WRITE;
      EX_MEM_READ   <= ID_MEM_READ;
      EX_MEM_WRITE  <= ID_MEM_WRITE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding priority, x0/immediate,
// load-use bubbles, stall/flush, store data and asynchronous reset.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ID_VALID;
  logic        ID_READY;
  logic [31:0] ID_PC, ID_DATA1, ID_DATA2, ID_IMM;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic        ID_USES_RS1, ID_USES_RS2, ID_OP1_SEL, ID_OP2_SEL;
  logic [4:0]  ID_SELECT;
  logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic [31:0] ALU_RESULT;
  logic [4:0]  MEM_RD, WB_RD;
  logic        MEM_REG_WRITE, WB_REG_WRITE;
  logic [31:0] MEM_RESULT, WB_RESULT;
  logic        STALL, FLUSH;
  logic        EX_VALID;
  logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_STORE_DATA;
  logic [4:0]  EX_SELECT, EX_RD;
  logic        EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE;
  logic        LOAD_USE_HAZARD;
  logic [31:0] BUBBLE_COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_PC(ID_PC), .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2), .ID_IMM(ID_IMM),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .ID_OP1_SEL(ID_OP1_SEL), .ID_OP2_SEL(ID_OP2_SEL), .ID_SELECT(ID_SELECT),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .ALU_RESULT(ALU_RESULT), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
    .MEM_REG_WRITE(MEM_REG_WRITE), .WB_REG_WRITE(WB_REG_WRITE),
    .MEM_RESULT(MEM_RESULT), .WB_RESULT(WB_RESULT), .STALL(STALL), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_SELECT(EX_SELECT), .EX_RD(EX_RD),
    .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
    .LOAD_USE_HAZARD(LOAD_USE_HAZARD), .BUBBLE_COUNT(BUBBLE_COUNT)
  );

  task automatic idle_inputs();
    ID_VALID = 0; ID_PC = 0; ID_DATA1 = 0; ID_DATA2 = 0; ID_IMM = 0;
    ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    ID_OP1_SEL = 0; ID_OP2_SEL = 0; ID_SELECT = 0;
    ID_REG_WRITE = 0; ID_MEM_READ = 0; ID_MEM_WRITE = 0;
    ALU_RESULT = 0; MEM_RD = 0; WB_RD = 0; MEM_REG_WRITE = 0; WB_REG_WRITE = 0;
    MEM_RESULT = 0; WB_RESULT = 0; STALL = 0; FLUSH = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Decode a load "lw xRd" with no register sources and clock it into EX.
  task automatic load_into_ex(input logic [4:0] rd);
    idle_inputs();
    ID_VALID = 1; ID_RD = rd; ID_REG_WRITE = 1; ID_MEM_READ = 1; ID_OP2_SEL = 1;
    ID_PC = 32'h200;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 0;
    step(); step();
    #1;
    RESET = 1;
    #1;
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL rst_valid got %b exp 0", EX_VALID); else n_pass++;
    n_checks++; if (EX_DATA1 !== 32'd0) $display("FAIL rst_data1 got %h exp 0", EX_DATA1); else n_pass++;
    n_checks++; if (BUBBLE_COUNT !== 32'd0) $display("FAIL rst_count got %0d exp 0", BUBBLE_COUNT); else n_pass++;
    n_checks++; if (ID_READY !== 1'b1) $display("FAIL rst_ready got %b exp 1", ID_READY); else n_pass++;
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    ID_VALID = 1; ID_RD = 5; ID_REG_WRITE = 1; ID_PC = 32'h100;
    step();
    // sub x6,x5,x5 with EX, MEM and WB all writing x5
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h104; ID_RS1 = 5; ID_RS2 = 5; ID_RD = 6;
    ID_USES_RS1 = 1; ID_USES_RS2 = 1; ID_SELECT = 5'b00001; ID_REG_WRITE = 1;
    ID_DATA1 = 32'd1; ID_DATA2 = 32'd1;
    ALU_RESULT = 32'd25;
    MEM_REG_WRITE = 1; MEM_RD = 5; MEM_RESULT = 32'd7;
    WB_REG_WRITE = 1; WB_RD = 5; WB_RESULT = 32'd9;
    step();
    n_checks++; if (EX_DATA1 !== 32'd25) $display("FAIL fwd_ex_d1 got %0d exp 25", EX_DATA1); else n_pass++;
    n_checks++; if (EX_DATA2 !== 32'd25) $display("FAIL fwd_ex_d2 got %0d exp 25", EX_DATA2); else n_pass++;
    n_checks++; if (EX_SELECT !== 5'b00001) $display("FAIL fwd_select got %b exp 00001", EX_SELECT); else n_pass++;
    n_checks++; if (EX_RD !== 5'd6) $display("FAIL fwd_rd got %0d exp 6", EX_RD); else n_pass++;
    // EX now holds x6, so the EX match is gone and MEM wins
    step();
    n_checks++; if (EX_DATA1 !== 32'd7) $display("FAIL fwd_mem_d1 got %0d exp 7", EX_DATA1); else n_pass++;
    n_checks++; if (EX_DATA2 !== 32'd7) $display("FAIL fwd_mem_d2 got %0d exp 7", EX_DATA2); else n_pass++;
    MEM_REG_WRITE = 0;
    step();
    n_checks++; if (EX_DATA1 !== 32'd9) $display("FAIL fwd_wb_d1 got %0d exp 9", EX_DATA1); else n_pass++;
    WB_REG_WRITE = 0;
    step();
    n_checks++; if (EX_DATA2 !== 32'd1) $display("FAIL fwd_none_d2 got %0d exp 1", EX_DATA2); else n_pass++;
  endtask

  task automatic test_x0_imm();
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h110; ID_RS1 = 0; ID_DATA1 = 0; ID_USES_RS1 = 1;
    ID_RD = 1; ID_OP2_SEL = 1; ID_IMM = 32'd20; ID_SELECT = 5'b00000; ID_REG_WRITE = 1;
    MEM_REG_WRITE = 1; MEM_RD = 0; MEM_RESULT = 32'd55;
    step();
    n_checks++; if (EX_DATA1 !== 32'd0) $display("FAIL x0_d1 got %0d exp 0", EX_DATA1); else n_pass++;
    n_checks++; if (EX_DATA2 !== 32'd20) $display("FAIL imm_d2 got %0d exp 20", EX_DATA2); else n_pass++;
    n_checks++; if (EX_SELECT !== 5'd0) $display("FAIL imm_select got %b exp 00000", EX_SELECT); else n_pass++;
    n_checks++; if (EX_VALID !== 1'b1) $display("FAIL imm_valid got %b exp 1", EX_VALID); else n_pass++;
  endtask

  task automatic test_load_use();
    load_into_ex(5'd3);
    // add x4,x3,x2 right behind the load
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h204; ID_RS1 = 3; ID_RS2 = 2; ID_RD = 4;
    ID_USES_RS1 = 1; ID_USES_RS2 = 1; ID_REG_WRITE = 1; ID_DATA1 = 32'h11; ID_DATA2 = 32'h22;
    #1;
    n_checks++; if (LOAD_USE_HAZARD !== 1'b1) $display("FAIL lu_hazard got %b exp 1", LOAD_USE_HAZARD); else n_pass++;
    n_checks++; if (ID_READY !== 1'b0) $display("FAIL lu_ready got %b exp 0", ID_READY); else n_pass++;
    step();
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL lu_bubble_valid got %b exp 0", EX_VALID); else n_pass++;
    n_checks++; if (BUBBLE_COUNT !== 32'd1) $display("FAIL lu_count got %0d exp 1", BUBBLE_COUNT); else n_pass++;
    MEM_REG_WRITE = 1; MEM_RD = 3; MEM_RESULT = 32'hDEADBEEF;
    #1;
    n_checks++; if (ID_READY !== 1'b1) $display("FAIL lu_ready_after got %b exp 1", ID_READY); else n_pass++;
    step();
    n_checks++; if (EX_DATA1 !== 32'hDEADBEEF) $display("FAIL lu_mem_fwd got %h exp deadbeef", EX_DATA1); else n_pass++;
    n_checks++; if (EX_DATA2 !== 32'h22) $display("FAIL lu_d2 got %h exp 22", EX_DATA2); else n_pass++;
    n_checks++; if (EX_RD !== 5'd4) $display("FAIL lu_rd got %0d exp 4", EX_RD); else n_pass++;
    // Same pair, but rs1 is not read: no hazard
    load_into_ex(5'd3);
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h208; ID_RS1 = 3; ID_RS2 = 2; ID_RD = 4;
    ID_USES_RS1 = 0; ID_USES_RS2 = 1; ID_REG_WRITE = 1; ID_DATA1 = 32'h11; ID_DATA2 = 32'h22;
    #1;
    n_checks++; if (LOAD_USE_HAZARD !== 1'b0) $display("FAIL nolu_hazard got %b exp 0", LOAD_USE_HAZARD); else n_pass++;
    step();
    n_checks++; if (EX_VALID !== 1'b1) $display("FAIL nolu_valid got %b exp 1", EX_VALID); else n_pass++;
    n_checks++; if (BUBBLE_COUNT !== 32'd1) $display("FAIL nolu_count got %0d exp 1", BUBBLE_COUNT); else n_pass++;
  endtask

  task automatic test_stall_flush();
    // EX holds the add from the previous test: rd=4, data2=0x22, pc=0x208
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h300; ID_RD = 9; ID_DATA2 = 32'h99; ID_REG_WRITE = 1;
    STALL = 1;
    #1;
    n_checks++; if (ID_READY !== 1'b0) $display("FAIL stall_ready got %b exp 0", ID_READY); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (EX_RD !== 5'd4) $display("FAIL stall_rd[%0d] got %0d exp 4", i, EX_RD); else n_pass++;
      n_checks++; if (EX_PC !== 32'h208) $display("FAIL stall_pc[%0d] got %h exp 208", i, EX_PC); else n_pass++;
      n_checks++; if (EX_VALID !== 1'b1) $display("FAIL stall_valid[%0d] got %b exp 1", i, EX_VALID); else n_pass++;
    end
    FLUSH = 1;
    step();
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL flushstall_valid got %b exp 0", EX_VALID); else n_pass++;
    n_checks++; if (EX_REG_WRITE !== 1'b0) $display("FAIL flushstall_rw got %b exp 0", EX_REG_WRITE); else n_pass++;
    n_checks++; if (EX_RD !== 5'd0) $display("FAIL flushstall_rd got %0d exp 0", EX_RD); else n_pass++;
    // Flush together with a load-use hazard: bubble, counter untouched
    load_into_ex(5'd3);
    idle_inputs();
    ID_VALID = 1; ID_RS1 = 3; ID_USES_RS1 = 1; ID_RD = 4; ID_REG_WRITE = 1;
    FLUSH = 1;
    #1;
    n_checks++; if (LOAD_USE_HAZARD !== 1'b1) $display("FAIL flushlu_hazard got %b exp 1", LOAD_USE_HAZARD); else n_pass++;
    step();
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL flushlu_valid got %b exp 0", EX_VALID); else n_pass++;
    n_checks++; if (BUBBLE_COUNT !== 32'd1) $display("FAIL flushlu_count got %0d exp 1", BUBBLE_COUNT); else n_pass++;
  endtask

  task automatic test_store();
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h400; ID_RS1 = 2; ID_RS2 = 7; ID_USES_RS1 = 1; ID_USES_RS2 = 1;
    ID_OP2_SEL = 1; ID_IMM = 32'd8; ID_MEM_WRITE = 1; ID_DATA1 = 32'h100; ID_DATA2 = 32'h5;
    MEM_REG_WRITE = 1; MEM_RD = 7; MEM_RESULT = 32'h1234;
    step();
    n_checks++; if (EX_DATA2 !== 32'd8) $display("FAIL st_d2 got %h exp 8", EX_DATA2); else n_pass++;
    n_checks++; if (EX_STORE_DATA !== 32'h1234) $display("FAIL st_data got %h exp 1234", EX_STORE_DATA); else n_pass++;
    n_checks++; if (EX_MEM_WRITE !== 1'b1) $display("FAIL st_memwrite got %b exp 1", EX_MEM_WRITE); else n_pass++;
    n_checks++; if (EX_DATA1 !== 32'h100) $display("FAIL st_d1 got %h exp 100", EX_DATA1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      load_into_ex(5'd3);
      idle_inputs();
      ID_VALID = 1; ID_RS1 = 3; ID_USES_RS1 = 1; ID_RD = 4;
      step();
    end
    n_checks++; if (BUBBLE_COUNT !== 32'd4) $display("FAIL mid_count_pre got %0d exp 4", BUBBLE_COUNT); else n_pass++;
    idle_inputs();
    ID_VALID = 1; ID_PC = 32'h500; ID_RD = 8; ID_REG_WRITE = 1; ID_DATA1 = 32'h77;
    step();
    n_checks++; if (EX_VALID !== 1'b1) $display("FAIL mid_valid_pre got %b exp 1", EX_VALID); else n_pass++;
    STALL = 1;
    #3;
    RESET = 0;
    #1;
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL mid_valid got %b exp 0", EX_VALID); else n_pass++;
    n_checks++; if (BUBBLE_COUNT !== 32'd0) $display("FAIL mid_count got %0d exp 0", BUBBLE_COUNT); else n_pass++;
    n_checks++; if (EX_RD !== 5'd0) $display("FAIL mid_rd got %0d exp 0", EX_RD); else n_pass++;
    n_checks++; if (EX_PC !== 32'd0) $display("FAIL mid_pc got %h exp 0", EX_PC); else n_pass++;
    n_checks++; if (EX_REG_WRITE !== 1'b0) $display("FAIL mid_rw got %b exp 0", EX_REG_WRITE); else n_pass++;
    step();
    n_checks++; if (EX_VALID !== 1'b0) $display("FAIL mid_hold got %b exp 0", EX_VALID); else n_pass++;
    RESET = 1; STALL = 0;
    step();
    n_checks++; if (EX_PC !== 32'h500) $display("FAIL mid_first_cap got %h exp 500", EX_PC); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_x0_imm();
    test_load_use();
    test_stall_flush();
    test_store();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
